// File: rtl/ff_response_checker_pkg.sv
// Shared definitions for the flip-flop response checker: FSM encoding,
// error-code bit positions and the supported flip-flop behaviours.
package ff_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } chk_state_t;

  localparam int ERR_Q  = 0;
  localparam int ERR_QN = 1;

  // Flip-flop types are carried as 3-character ASCII so callers can pass "DFF"/"TFF".
  localparam logic [23:0] FF_DFF = "DFF";
  localparam logic [23:0] FF_TFF = "TFF";

  function automatic logic ff_type_ok(input logic [23:0] ff_type);
    return (ff_type == FF_DFF) || (ff_type == FF_TFF);
  endfunction

endpackage

// File: rtl/ff_response_checker_if.sv
// Observation bundle for the flip-flop under test: its reset, data input and
// both outputs. The stimulus side drives it, the checker only listens.
interface ff_response_checker_if;
  logic dut_rst;
  logic ff_in;
  logic ff_q;
  logic ff_qn;

  modport master (output dut_rst, output ff_in, output ff_q, output ff_qn);
  modport slave  (input  dut_rst, input  ff_in, input  ff_q, input  ff_qn);
endinterface

// File: rtl/ff_response_checker_ref_model.sv
// Golden flip-flop mirroring the DUT; advances only while checking is enabled
// so that its state lines up with what the FSM considers synchronised.
module ff_ref_model
  import ff_check_pkg::*;
#(
  parameter logic [23:0] FF_TYPE = FF_DFF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic dut_rst,
  input  logic ff_in,
  output logic exp_q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      exp_q <= 1'b0;
    end else if (en) begin
      if (dut_rst)
        exp_q <= 1'b0;
      else if (FF_TYPE == FF_TFF)
        exp_q <= exp_q ^ ff_in;
      else
        exp_q <= ff_in;
    end
  end

endmodule

// File: rtl/ff_response_checker.sv
// Receiving end of the flip-flop stimulus stream: compares the DUT against a
// golden flip-flop and keeps error/check counters plus a first-failure capture.
//
// state | meaning
// IDLE  | checking disabled, counters and capture held
// SYNC  | waiting until the DUT state is known (DFF: one enabled cycle, TFF: a dut_rst cycle)
// CHECK | comparing every cycle
// HALT  | stopped after the first error (STOP_ON_ERR=1); only rst leaves
module ff_response_checker
  import ff_check_pkg::*;
#(
  parameter logic [23:0] FF_TYPE     = FF_DFF,
  parameter int          CNT_W       = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  ff_response_checker_if.slave    probe,
  output logic                    err_pulse,
  output logic [1:0]              err_code,
  output logic [CNT_W-1:0]        err_count,
  output logic [CNT_W-1:0]        check_count,
  output logic [CNT_W-1:0]        first_err_cycle,
  output logic [1:0]              first_err_code,
  output logic                    locked,
  output logic                    halted
);

  if (!ff_type_ok(FF_TYPE)) begin : g_bad_ff_type
    $error("ff_response_checker: FF_TYPE must be \"DFF\" or \"TFF\"");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_t       state, state_nxt;
  logic             exp_q;
  logic [1:0]       code;
  logic             in_check;
  logic             mismatch;
  logic             sync_done;
  logic             first_err_valid;
  logic [CNT_W-1:0] check_count_nxt;

  ff_ref_model #(.FF_TYPE(FF_TYPE)) u_ref (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .dut_rst (probe.dut_rst),
    .ff_in   (probe.ff_in),
    .exp_q   (exp_q)
  );

  // The complement check ignores dut_rst: Qn must track ~Q at all times.
  always_comb begin
    code         = 2'b00;
    code[ERR_Q]  = (probe.ff_q != exp_q);
    code[ERR_QN] = (probe.ff_qn == probe.ff_q);
  end

  assign in_check        = (state == CHECK);
  assign mismatch        = in_check && (code != 2'b00);
  assign sync_done       = (FF_TYPE == FF_TFF) ? probe.dut_rst : 1'b1;
  assign check_count_nxt = (check_count == CNT_MAX) ? check_count : check_count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    locked    = 1'b0;
    halted    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en)
          state_nxt = SYNC;
      end
      SYNC: begin
        if (!en)
          state_nxt = IDLE;
        else if (sync_done)
          state_nxt = CHECK;
      end
      CHECK: begin
        locked = 1'b1;
        if (STOP_ON_ERR && mismatch)
          state_nxt = HALT;
        else if (!en)
          state_nxt = IDLE;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A compare still happens on the edge where en falls, so its result is kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_pulse       <= 1'b0;
      err_code        <= 2'b00;
      err_count       <= '0;
      check_count     <= '0;
      first_err_cycle <= '0;
      first_err_code  <= 2'b00;
      first_err_valid <= 1'b0;
    end else begin
      err_pulse <= mismatch;
      err_code  <= mismatch ? code : 2'b00;
      if (in_check) begin
        check_count <= check_count_nxt;
        if (mismatch) begin
          if (err_count != CNT_MAX)
            err_count <= err_count + CNT_W'(1);
          if (!first_err_valid) begin
            first_err_valid <= 1'b1;
            first_err_cycle <= check_count_nxt;
            first_err_code  <= code;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ff_response_checker.sv
// Directed bench for ff_response_checker: DFF, TFF, stop-on-error and
// narrow-counter instances observe one shared stimulus stream.
module tb_ff_response_checker;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  logic dq = 1'b0;
  logic tq = 1'b0;

  ff_response_checker_if ifd ();
  ff_response_checker_if ift ();

  logic d_pulse, d_locked, d_halted; logic [1:0] d_code, d_fcode; logic [15:0] d_ecnt, d_ccnt, d_fcyc;
  logic t_pulse, t_locked, t_halted; logic [1:0] t_code, t_fcode; logic [15:0] t_ecnt, t_ccnt, t_fcyc;
  logic s_pulse, s_locked, s_halted; logic [1:0] s_code, s_fcode; logic [15:0] s_ecnt, s_ccnt, s_fcyc;
  logic q_pulse, q_locked, q_halted; logic [1:0] q_code, q_fcode; logic [3:0]  q_ecnt, q_ccnt, q_fcyc;

  ff_response_checker #(.FF_TYPE("DFF"), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_dff (
    .clk(clk), .rst(rst), .en(en), .probe(ifd), .err_pulse(d_pulse), .err_code(d_code),
    .err_count(d_ecnt), .check_count(d_ccnt), .first_err_cycle(d_fcyc), .first_err_code(d_fcode),
    .locked(d_locked), .halted(d_halted));

  ff_response_checker #(.FF_TYPE("TFF"), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_tff (
    .clk(clk), .rst(rst), .en(en), .probe(ift), .err_pulse(t_pulse), .err_code(t_code),
    .err_count(t_ecnt), .check_count(t_ccnt), .first_err_cycle(t_fcyc), .first_err_code(t_fcode),
    .locked(t_locked), .halted(t_halted));

  ff_response_checker #(.FF_TYPE("DFF"), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_stop (
    .clk(clk), .rst(rst), .en(en), .probe(ifd), .err_pulse(s_pulse), .err_code(s_code),
    .err_count(s_ecnt), .check_count(s_ccnt), .first_err_cycle(s_fcyc), .first_err_code(s_fcode),
    .locked(s_locked), .halted(s_halted));

  ff_response_checker #(.FF_TYPE("DFF"), .CNT_W(4), .STOP_ON_ERR(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .probe(ifd), .err_pulse(q_pulse), .err_code(q_code),
    .err_count(q_ecnt), .check_count(q_ccnt), .first_err_cycle(q_fcyc), .first_err_code(q_fcode),
    .locked(q_locked), .halted(q_halted));

  // One clock: present inputs, let the bench flip-flops advance at the edge, return at negedge.
  task automatic step(input logic d, input logic dr, input logic bad_q, input logic bad_qn);
    logic qd;
    qd = dq ^ bad_q;
    ifd.ff_in = d; ifd.dut_rst = dr; ifd.ff_q = qd; ifd.ff_qn = bad_qn ? qd : ~qd;
    ift.ff_in = d; ift.dut_rst = dr; ift.ff_q = tq; ift.ff_qn = ~tq;
    @(posedge clk);
    dq = dr ? 1'b0 : d;
    tq = dr ? 1'b0 : (tq ^ d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom);
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    checks++; if (d_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b want 0", d_pulse); end
    checks++; if (d_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %b want 00", d_code); end
    checks++; if (d_ecnt !== 16'd0) begin errors++; $display("FAIL reset_err_count: got %0d want 0", d_ecnt); end
    checks++; if (d_ccnt !== 16'd0) begin errors++; $display("FAIL reset_check_count: got %0d want 0", d_ccnt); end
    checks++; if (d_fcyc !== 16'd0) begin errors++; $display("FAIL reset_first_err_cycle: got %0d want 0", d_fcyc); end
    checks++; if (d_fcode !== 2'b00) begin errors++; $display("FAIL reset_first_err_code: got %b want 00", d_fcode); end
    checks++; if (d_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", d_locked); end
    checks++; if (d_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", d_halted); end
    checks++; if (t_locked !== 1'b0) begin errors++; $display("FAIL reset_tff_locked: got %b want 0", t_locked); end
    checks++; if (s_halted !== 1'b0) begin errors++; $display("FAIL reset_stop_halted: got %b want 0", s_halted); end
    checks++; if (q_ccnt !== 4'd0) begin errors++; $display("FAIL reset_sat_check_count: got %0d want 0", q_ccnt); end
    rst = 1'b1; en = 1'b0;
  endtask

  task automatic test_dff_clean();
    do_reset();
    en = 1'b1; pulses = 0;
    for (int i = 0; i <= 100; i++) begin
      step(1'($urandom), 1'b0, 1'b0, 1'b0);
      if (d_pulse === 1'b1) pulses++;
      if (i == 0) begin
        checks++; if (d_locked !== 1'b0) begin errors++; $display("FAIL dff_locked_sync: got %b want 0", d_locked); end
      end
      if (i == 1) begin
        checks++; if (d_locked !== 1'b1) begin errors++; $display("FAIL dff_locked_check: got %b want 1", d_locked); end
        checks++; if (d_ccnt !== 16'd0) begin errors++; $display("FAIL dff_first_count: got %0d want 0", d_ccnt); end
      end
      if (i == 2) begin
        checks++; if (d_ccnt !== 16'd1) begin errors++; $display("FAIL dff_second_count: got %0d want 1", d_ccnt); end
      end
    end
    checks++; if (d_ecnt !== 16'd0) begin errors++; $display("FAIL dff_clean_err_count: got %0d want 0", d_ecnt); end
    checks++; if (d_ccnt !== 16'd99) begin errors++; $display("FAIL dff_clean_check_count: got %0d want 99", d_ccnt); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL dff_clean_pulses: got %0d want 0", pulses); end
    checks++; if (q_ccnt !== 4'hF) begin errors++; $display("FAIL dff_clean_sat_count: got %0d want 15", q_ccnt); end
    en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (d_locked !== 1'b0) begin errors++; $display("FAIL dff_disable_locked: got %b want 0", d_locked); end
    checks++; if (d_ecnt !== 16'd0) begin errors++; $display("FAIL dff_disable_err_count: got %0d want 0", d_ecnt); end
  endtask

  task automatic test_tff_sync();
    do_reset();
    en = 1'b1; pulses = 0;
    for (int i = 0; i < 5; i++) step(1'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (t_ccnt !== 16'd0) begin errors++; $display("FAIL tff_sync_count: got %0d want 0", t_ccnt); end
    checks++; if (t_locked !== 1'b0) begin errors++; $display("FAIL tff_sync_locked: got %b want 0", t_locked); end
    step(1'($urandom), 1'b1, 1'b0, 1'b0);
    checks++; if (t_locked !== 1'b1) begin errors++; $display("FAIL tff_lock_after_rst: got %b want 1", t_locked); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (t_pulse === 1'b1) pulses++;
    end
    checks++; if (t_ecnt !== 16'd0) begin errors++; $display("FAIL tff_toggle_err_count: got %0d want 0", t_ecnt); end
    checks++; if (t_ccnt !== 16'd4) begin errors++; $display("FAIL tff_toggle_check_count: got %0d want 4", t_ccnt); end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    if (t_pulse === 1'b1) pulses++;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    if (t_pulse === 1'b1) pulses++;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL tff_pulses: got %0d want 0", pulses); end
    checks++; if (t_ccnt !== 16'd6) begin errors++; $display("FAIL tff_rst_in_check_count: got %0d want 6", t_ccnt); end
    checks++; if (t_code !== 2'b00) begin errors++; $display("FAIL tff_err_code: got %b want 00", t_code); end
    checks++; if ({t_fcyc, t_fcode} !== 18'd0) begin errors++; $display("FAIL tff_first_err: got %0d/%b want 0/00", t_fcyc, t_fcode); end
    checks++; if (t_halted !== 1'b0) begin errors++; $display("FAIL tff_halted: got %b want 0", t_halted); end
    en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_inject();
    do_reset();
    en = 1'b1; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'($urandom), 1'b0, (i == 11) || (i == 26), (i == 21) || (i == 26));
      if (d_pulse === 1'b1) pulses++;
      if (i == 11) begin
        checks++; if (d_pulse !== 1'b1) begin errors++; $display("FAIL inj_q_pulse: got %b want 1", d_pulse); end
        checks++; if (d_code !== 2'b01) begin errors++; $display("FAIL inj_q_code: got %b want 01", d_code); end
        checks++; if (d_fcyc !== 16'd10) begin errors++; $display("FAIL inj_first_cycle: got %0d want 10", d_fcyc); end
        checks++; if (d_fcode !== 2'b01) begin errors++; $display("FAIL inj_first_code: got %b want 01", d_fcode); end
      end
      if (i == 12) begin
        checks++; if (d_pulse !== 1'b0) begin errors++; $display("FAIL inj_pulse_width: got %b want 0", d_pulse); end
      end
      if (i == 21) begin
        checks++; if (d_code !== 2'b10) begin errors++; $display("FAIL inj_qn_code: got %b want 10", d_code); end
      end
      if (i == 26) begin
        checks++; if (d_code !== 2'b11) begin errors++; $display("FAIL inj_both_code: got %b want 11", d_code); end
      end
    end
    checks++; if (d_ecnt !== 16'd3) begin errors++; $display("FAIL inj_err_count: got %0d want 3", d_ecnt); end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL inj_pulses: got %0d want 3", pulses); end
    checks++; if (d_fcyc !== 16'd10) begin errors++; $display("FAIL inj_first_cycle_held: got %0d want 10", d_fcyc); end
    checks++; if (d_fcode !== 2'b01) begin errors++; $display("FAIL inj_first_code_held: got %b want 01", d_fcode); end
    checks++; if (d_ccnt !== 16'd28) begin errors++; $display("FAIL inj_check_count: got %0d want 28", d_ccnt); end
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) step(1'($urandom), 1'b0, 1'b0, 1'b0);
    en = 1'b0;
    step(1'($urandom), 1'b0, 1'b1, 1'b0);
    checks++; if (d_pulse !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b want 1", d_pulse); end
    checks++; if (d_code !== 2'b01) begin errors++; $display("FAIL drop_code: got %b want 01", d_code); end
    checks++; if (d_locked !== 1'b0) begin errors++; $display("FAIL drop_locked: got %b want 0", d_locked); end
    step(1'($urandom), 1'b0, 1'b1, 1'b0);
    checks++; if (d_pulse !== 1'b0) begin errors++; $display("FAIL idle_pulse: got %b want 0", d_pulse); end
    en = 1'b1;
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (d_locked !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", d_locked); end
    checks++; if (d_ecnt !== 16'd1) begin errors++; $display("FAIL drop_err_kept: got %0d want 1", d_ecnt); end
    checks++; if (d_fcyc !== 16'd3) begin errors++; $display("FAIL drop_first_cycle: got %0d want 3", d_fcyc); end
    checks++; if (d_ccnt !== 16'd4) begin errors++; $display("FAIL drop_check_count: got %0d want 4", d_ccnt); end
  endtask

  task automatic test_stop();
    do_reset();
    en = 1'b1;
    for (int i = 0; i <= 6; i++) step(1'($urandom), 1'b0, i == 6, 1'b0);
    checks++; if (s_pulse !== 1'b1) begin errors++; $display("FAIL stop_pulse: got %b want 1", s_pulse); end
    checks++; if (s_halted !== 1'b1) begin errors++; $display("FAIL stop_halted: got %b want 1", s_halted); end
    checks++; if (s_locked !== 1'b0) begin errors++; $display("FAIL stop_locked: got %b want 0", s_locked); end
    checks++; if (s_code !== 2'b01) begin errors++; $display("FAIL stop_code: got %b want 01", s_code); end
    checks++; if (s_fcyc !== 16'd5) begin errors++; $display("FAIL stop_first_cycle: got %0d want 5", s_fcyc); end
    checks++; if (s_fcode !== 2'b01) begin errors++; $display("FAIL stop_first_code: got %b want 01", s_fcode); end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'($urandom), 1'b0, 1'b1, 1'b1);
      if (s_pulse === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL halt_pulses: got %0d want 0", pulses); end
    checks++; if (s_ecnt !== 16'd1) begin errors++; $display("FAIL halt_err_count: got %0d want 1", s_ecnt); end
    checks++; if (s_ccnt !== 16'd5) begin errors++; $display("FAIL halt_check_count: got %0d want 5", s_ccnt); end
    en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (s_halted !== 1'b1) begin errors++; $display("FAIL halt_ignores_en: got %b want 1", s_halted); end
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    checks++; if (s_halted !== 1'b0) begin errors++; $display("FAIL halt_rst_clear: got %b want 0", s_halted); end
    checks++; if (s_ecnt !== 16'd0) begin errors++; $display("FAIL halt_rst_count: got %0d want 0", s_ecnt); end
  endtask

  task automatic test_sat();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 22; i++) step(1'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (q_ccnt !== 4'hF) begin errors++; $display("FAIL sat_check_count: got %0d want 15", q_ccnt); end
    checks++; if (q_ecnt !== 4'h0) begin errors++; $display("FAIL sat_clean_errs: got %0d want 0", q_ecnt); end
    checks++; if (q_locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b want 1", q_locked); end
    step(1'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (q_ccnt !== 4'hF) begin errors++; $display("FAIL sat_count_held: got %0d want 15", q_ccnt); end
    step(1'($urandom), 1'b0, 1'b1, 1'b0);
    checks++; if (q_pulse !== 1'b1) begin errors++; $display("FAIL sat_pulse: got %b want 1", q_pulse); end
    checks++; if (q_code !== 2'b01) begin errors++; $display("FAIL sat_code: got %b want 01", q_code); end
    checks++; if (q_fcyc !== 4'hF) begin errors++; $display("FAIL sat_first_cycle: got %0d want 15", q_fcyc); end
    checks++; if (q_fcode !== 2'b01) begin errors++; $display("FAIL sat_first_code: got %b want 01", q_fcode); end
    checks++; if (q_ecnt !== 4'h1) begin errors++; $display("FAIL sat_first_err_count: got %0d want 1", q_ecnt); end
    for (int i = 0; i < 17; i++) step(1'($urandom), 1'b0, 1'b1, 1'b0);
    checks++; if (q_ecnt !== 4'hF) begin errors++; $display("FAIL sat_err_count: got %0d want 15", q_ecnt); end
    checks++; if (q_halted !== 1'b0) begin errors++; $display("FAIL sat_halted: got %b want 0", q_halted); end
    en = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    en  = 1'b0;
    test_reset();
    test_dff_clean();
    test_tff_sync();
    test_inject();
    test_en_drop();
    test_stop();
    test_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
